brlite_svc_queue: RTL and testbench

BRLITE_SVC_QUEUE -- requirements
Module: brlite_svc_queue

---
 rtl/brlite_svc_queue.sv | 90 +++++++++
 tb/tb_brlite_svc_queue.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/brlite_svc_queue.sv
// BrLite service-message queue: captures router local-port requests into a
// circular buffer and presents the head message to the NI.
package brlite_svc_pkg;
  typedef struct packed {
    logic [7:0]  ksvc;
    logic [7:0]  seq_source;
    logic [15:0] producer;
    logic [31:0] payload;
  } brlite_svc_t;
endpackage

module brlite_svc_queue
  import brlite_svc_pkg::*;
#(
  parameter int BUFFER_SIZE = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         rx_req_i,
  output logic                         rx_ack_o,
  input  brlite_svc_t                  rx_data_i,
  output logic                         br_svc_rx_o,
  input  logic                         br_svc_ack_i,
  output brlite_svc_t                  br_svc_data_o,
  input  logic                         flush_i,
  output logic [$clog2(BUFFER_SIZE):0] svc_count_o
);

  localparam int AW = $clog2(BUFFER_SIZE);
  localparam int CW = AW + 1;

  brlite_svc_t   r_mem [BUFFER_SIZE];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_ack;
  logic          r_rx;

  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_nxt;

  // Full uses the registered count only, so a same-cycle pop never frees a slot early.
  assign w_full = (r_count == CW'(BUFFER_SIZE));
  assign w_push = rx_req_i && !r_ack && !w_full && !flush_i;
  assign w_pop  = br_svc_ack_i && (r_count != '0) && !flush_i;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ack    <= 1'b0;
      r_rx     <= 1'b0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ack    <= 1'b0;
      r_rx     <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_rx    <= (w_count_nxt != '0);
      // Ack lasts one cycle and itself blocks the next push, so a held request is taken once per two edges.
      r_ack   <= w_push;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= rx_data_i;
  end

  assign rx_ack_o      = r_ack;
  assign br_svc_rx_o   = r_rx;
  assign br_svc_data_o = r_mem[r_rd_ptr];
  assign svc_count_o   = r_count;

endmodule

// File: tb/tb_brlite_svc_queue.sv
// Directed bench for brlite_svc_queue: queue-based reference model checked
// every cycle, plus literal expectations at key points of each scenario.
module tb_brlite_svc_queue;
  import brlite_svc_pkg::*;

  localparam int BS = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        rx_req_i = 1'b0;
  logic        rx_ack_o;
  brlite_svc_t rx_data_i = '0;
  logic        br_svc_rx_o;
  logic        br_svc_ack_i = 1'b0;
  brlite_svc_t br_svc_data_o;
  logic        flush_i = 1'b0;
  logic [$clog2(BS):0] svc_count_o;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  brlite_svc_t m_q[$];
  bit          m_ack = 1'b0;

  brlite_svc_queue #(.BUFFER_SIZE(BS)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .rx_req_i     (rx_req_i),
    .rx_ack_o     (rx_ack_o),
    .rx_data_i    (rx_data_i),
    .br_svc_rx_o  (br_svc_rx_o),
    .br_svc_ack_i (br_svc_ack_i),
    .br_svc_data_o(br_svc_data_o),
    .flush_i      (flush_i),
    .svc_count_o  (svc_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an ordered list of entries plus the one-cycle ack flag.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_q.delete();
      m_ack = 1'b0;
    end else if (flush_i) begin
      m_q.delete();
      m_ack = 1'b0;
    end else begin
      bit push, pop;
      push = rx_req_i && !m_ack && (m_q.size() < BS);
      pop  = br_svc_ack_i && (m_q.size() > 0);
      if (pop)  void'(m_q.pop_front());
      if (push) m_q.push_back(rx_data_i);
      m_ack = push;
    end
  end

  always @(negedge clk_i) begin
    check("ack", 64'(rx_ack_o), 64'(m_ack));
    check("rx", 64'(br_svc_rx_o), 64'(m_q.size() != 0));
    check("count", 64'(svc_count_o), 64'(m_q.size()));
    if (m_q.size() != 0) check("head", br_svc_data_o, m_q[0]);
  end

  function automatic brlite_svc_t mk(input logic [31:0] p);
    brlite_svc_t s;
    s.ksvc       = p[7:0] ^ 8'h5A;
    s.seq_source = p[15:8];
    s.producer   = ~p[15:0];
    s.payload    = p;
    return s;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [31:0] p);
    int n;
    rx_data_i = mk(p);
    rx_req_i  = 1'b1;
    step();
    n = 0;
    while (!rx_ack_o && n < 20) begin
      step();
      n++;
    end
    check("send_ack", 64'(rx_ack_o), 64'd1);
    rx_req_i = 1'b0;
  endtask

  task automatic pop(input logic [31:0] exp);
    check("pop_head", 64'(br_svc_data_o.payload), 64'(exp));
    br_svc_ack_i = 1'b1;
    step();
    br_svc_ack_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  acks;
    logic [31:0] exp;
    int          n;

    #12 rst_ni = 1'b1;
    step();
    check("rst_count", 64'(svc_count_o), 64'd0);
    check("rst_rx", 64'(br_svc_rx_o), 64'd0);
    check("rst_ack", 64'(rx_ack_o), 64'd0);

    // Single message
    rx_data_i = mk(32'hCAFE0001);
    rx_data_i.ksvc = 8'h12;
    rx_req_i = 1'b1;
    step();
    check("single_ack", 64'(rx_ack_o), 64'd1);
    check("single_rx", 64'(br_svc_rx_o), 64'd1);
    check("single_count", 64'(svc_count_o), 64'd1);
    check("single_payload", 64'(br_svc_data_o.payload), 64'hCAFE0001);
    check("single_ksvc", 64'(br_svc_data_o.ksvc), 64'h12);
    rx_req_i = 1'b0;
    step();
    check("single_ack_clr", 64'(rx_ack_o), 64'd0);
    br_svc_ack_i = 1'b1;
    step();
    br_svc_ack_i = 1'b0;
    check("single_pop_rx", 64'(br_svc_rx_o), 64'd0);
    check("single_pop_count", 64'(svc_count_o), 64'd0);

    // Fill to full, ninth request held off until a pop frees a slot
    for (int i = 1; i <= 8; i++) send(32'(i));
    step();
    check("full_count", 64'(svc_count_o), 64'd8);
    rx_data_i = mk(32'd9);
    rx_req_i  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("full_no_ack", 64'(rx_ack_o), 64'd0);
      check("full_hold", 64'(svc_count_o), 64'd8);
    end
    pop(32'd1);
    check("full_pop_no_push", 64'(rx_ack_o), 64'd0);
    check("full_pop_count", 64'(svc_count_o), 64'd7);
    step();
    check("ninth_ack", 64'(rx_ack_o), 64'd1);
    check("ninth_count", 64'(svc_count_o), 64'd8);
    rx_req_i = 1'b0;
    for (int i = 2; i <= 9; i++) pop(32'(i));
    check("drained", 64'(svc_count_o), 64'd0);

    // Held request: one capture per two edges
    rx_data_i = mk(32'h40);
    rx_req_i  = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      step();
      acks[i] = rx_ack_o;
    end
    rx_req_i = 1'b0;
    check("held_pattern", 64'(acks), 64'b1010);
    check("held_count", 64'(svc_count_o), 64'd2);
    pop(32'h40);
    pop(32'h40);

    // Simultaneous push and pop at count 3
    send(32'h30); send(32'h31); send(32'h32);
    step();
    rx_data_i = mk(32'h33);
    rx_req_i = 1'b1;
    br_svc_ack_i = 1'b1;
    step();
    rx_req_i = 1'b0;
    br_svc_ack_i = 1'b0;
    check("pp_count", 64'(svc_count_o), 64'd3);
    check("pp_ack", 64'(rx_ack_o), 64'd1);
    check("pp_head", 64'(br_svc_data_o.payload), 64'h31);
    pop(32'h31); pop(32'h32); pop(32'h33);

    // Twenty messages through the ring, wrapping the pointers
    exp = 32'd100;
    for (int i = 0; i < 20; i++) begin
      send(32'd100 + 32'(i));
      if (svc_count_o >= 5) begin
        pop(exp);
        exp++;
      end
    end
    n = 0;
    while (br_svc_rx_o && n < 20) begin
      pop(exp);
      exp++;
      n++;
    end
    check("wrap_last", 64'(exp), 64'd120);

    // Pop while empty is ignored
    br_svc_ack_i = 1'b1;
    step();
    br_svc_ack_i = 1'b0;
    check("empty_pop_count", 64'(svc_count_o), 64'd0);
    check("empty_pop_rx", 64'(br_svc_rx_o), 64'd0);

    // Flush beats a pending request
    for (int i = 0; i < 5; i++) send(32'h50 + 32'(i));
    step();
    check("pre_flush_count", 64'(svc_count_o), 64'd5);
    rx_data_i = mk(32'h55);
    rx_req_i = 1'b1;
    flush_i  = 1'b1;
    step();
    flush_i = 1'b0;
    check("flush_ack", 64'(rx_ack_o), 64'd0);
    check("flush_count", 64'(svc_count_o), 64'd0);
    check("flush_rx", 64'(br_svc_rx_o), 64'd0);
    step();
    check("post_flush_ack", 64'(rx_ack_o), 64'd1);
    check("post_flush_count", 64'(svc_count_o), 64'd1);
    rx_req_i = 1'b0;
    pop(32'h55);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 4; i++) send(32'h60 + 32'(i));
    rx_data_i = mk(32'h64);
    rx_req_i = 1'b1;
    step();
    check("pre_rst_count", 64'(svc_count_o), 64'd4);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_ack", 64'(rx_ack_o), 64'd0);
    check("arst_rx", 64'(br_svc_rx_o), 64'd0);
    check("arst_count", 64'(svc_count_o), 64'd0);
    step();
    rst_ni = 1'b1;
    step();
    check("post_rst_ack", 64'(rx_ack_o), 64'd1);
    check("post_rst_count", 64'(svc_count_o), 64'd1);
    rx_req_i = 1'b0;
    pop(32'h64);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
